i2s_rx: RTL

Slave I2S receiver for an external stereo ADC (PCM1808-class) that drives BCK, LRCK and DATA. It synchronises the three pins into the system clock domain and de-serialises MSB-first, 1-BCK-delayed I2S slots. It emits one left/right sample pair per frame with a single-cycle valid strobe. It is the capture counterpart of the codebase's PCM5102 transmitter and feeds the same 16-bit sample paths.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_rx_sync_edge.sv | 57 +++++
 rtl/i2s_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants for the I2S capture/playback paths.
//   SAMPLE_W_DEFAULT / CNT_W_DEFAULT : default sample and slot-counter widths
//   CH_LEFT / CH_RIGHT               : LRCK level per channel (shared with the transmitter)
//   HUNT / RUN                       : receiver FSM state encoding
package i2s_pkg;

    localparam int unsigned SAMPLE_W_DEFAULT = 16;
    localparam int unsigned CNT_W_DEFAULT    = 6;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// sync_edge: 2-flop synchroniser for one edge pin plus W data pins, with a
// registered rising-edge strobe on the edge pin.
//   clk, rst  : system clock, synchronous active-high reset
//   edge_in   : asynchronous pin whose rising edge is detected (BCK)
//   data_in   : asynchronous pins that are only synchronised (LRCK, DATA)
//   data_s    : synchronised data pins
//   rise      : one-clk strobe, 3 clk after an edge_in rising edge
module sync_edge #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         edge_in,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_s,
    output logic         rise
);

    logic [W-1:0] dmeta_q, dmeta_d;
    logic [W-1:0] dsync_q, dsync_d;
    logic         emeta_q, emeta_d;
    logic         esync_q, esync_d;
    logic         eprev_q, eprev_d;
    logic         rise_q,  rise_d;

    // Next-state: plain shift chain, edge strobe from sync vs. previous sync
    always_comb begin
        dmeta_d = data_in;
        dsync_d = dmeta_q;
        emeta_d = edge_in;
        esync_d = emeta_q;
        eprev_d = esync_q;
        rise_d  = esync_q & ~eprev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmeta_q <= '0;
            dsync_q <= '0;
            emeta_q <= 1'b0;
            esync_q <= 1'b0;
            eprev_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            dmeta_q <= dmeta_d;
            dsync_q <= dsync_d;
            emeta_q <= emeta_d;
            esync_q <= esync_d;
            eprev_q <= eprev_d;
            rise_q  <= rise_d;
        end
    end

    assign data_s = dsync_q;
    assign rise   = rise_q;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: slave I2S receiver. Synchronises BCK/LRCK/DATA, de-serialises
// MSB-first 1-BCK-delayed slots and emits one left/right pair per frame.
//   clk, rst      : system clock, synchronous active-high reset
//   bck_in        : I2S bit clock (async)
//   lrck_in       : I2S word select (async), low = left
//   din_in        : I2S serial data (async)
//   left_out      : last complete left sample, MSB-justified
//   right_out     : last complete right sample, MSB-justified
//   sample_valid  : one-clk pulse when left_out/right_out update
//   slot_bits     : BCK rises in the most recently closed slot (saturating)
//   locked        : set by the first LRCK transition after reset
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bck_in,
    input  logic                lrck_in,
    input  logic                din_in,
    output logic [SAMPLE_W-1:0] left_out,
    output logic [SAMPLE_W-1:0] right_out,
    output logic                sample_valid,
    output logic [CNT_W-1:0]    slot_bits,
    output logic                locked
);

    logic [1:0] pins_s;
    logic       rise;
    logic       lrck_s;
    logic       din_s;

    sync_edge #(.W(2)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .edge_in (bck_in),
        .data_in ({lrck_in, din_in}),
        .data_s  (pins_s),
        .rise    (rise)
    );

    assign lrck_s = pins_s[1];
    assign din_s  = pins_s[0];

    logic [0:0]          state_q,      state_d;
    logic                lrck_prev_q,  lrck_prev_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [SAMPLE_W-1:0] shift_q,      shift_d;
    logic [SAMPLE_W-1:0] left_hold_q,  left_hold_d;
    logic                left_ok_q,    left_ok_d;
    logic [SAMPLE_W-1:0] left_out_q,   left_out_d;
    logic [SAMPLE_W-1:0] right_out_q,  right_out_d;
    logic                valid_q,      valid_d;
    logic [CNT_W-1:0]    slot_bits_q,  slot_bits_d;
    logic                locked_q,     locked_d;

    logic [CNT_W-1:0]    cnt_sat;
    logic [SAMPLE_W-1:0] shift_w;

    // Shift register with the current bit merged in; bits past SAMPLE_W drop
    always_comb begin
        cnt_sat = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        shift_w = shift_q;
        for (int unsigned i = 0; i < SAMPLE_W; i++) begin
            if (32'(cnt_q) == SAMPLE_W - 1 - i) begin
                shift_w[i] = din_s;
            end
        end
    end

    // FSM + datapath; every state change is qualified by rise
    always_comb begin
        state_d     = state_q;
        lrck_prev_d = lrck_prev_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        valid_d     = 1'b0;
        slot_bits_d = slot_bits_q;
        locked_d    = locked_q;

        if (rise) begin
            lrck_prev_d = lrck_s;
            case (state_q)
                HUNT: begin
                    // First LRCK edge aligns us to a slot boundary; its bit is discarded
                    if (lrck_s != lrck_prev_q) begin
                        locked_d  = 1'b1;
                        cnt_d     = '0;
                        shift_d   = '0;
                        left_ok_d = 1'b0;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (lrck_s == lrck_prev_q) begin
                        shift_d = shift_w;
                        cnt_d   = cnt_sat;
                    end else begin
                        // 1-BCK delay: this bit is the LSB of the slot now closing
                        slot_bits_d = cnt_sat;
                        shift_d     = '0;
                        cnt_d       = '0;
                        if (lrck_prev_q == CH_LEFT) begin
                            left_hold_d = shift_w;
                            left_ok_d   = 1'b1;
                        end else if (lrck_prev_q == CH_RIGHT && left_ok_q) begin
                            left_out_d  = left_hold_q;
                            right_out_d = shift_w;
                            valid_d     = 1'b1;
                            left_ok_d   = 1'b0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            lrck_prev_q <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            left_out_q  <= '0;
            right_out_q <= '0;
            valid_q     <= 1'b0;
            slot_bits_q <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrck_prev_q <= lrck_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            valid_q     <= valid_d;
            slot_bits_q <= slot_bits_d;
            locked_q    <= locked_d;
        end
    end

    assign left_out     = left_out_q;
    assign right_out    = right_out_q;
    assign sample_valid = valid_q;
    assign slot_bits    = slot_bits_q;
    assign locked       = locked_q;

endmodule
